// File: rtl/device_uart.sv
// device_uart: memory-mapped 8N1 UART (TX FIFO, RX holding reg); DEVICE_UART_CORE_TAG_EN adds core tag frames
module device_uart #(
  parameter logic [9:0] BASE_ADDR      = 10'h000,
  parameter int         CLOCKS_PER_BIT = 16,
  parameter int         TX_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  device_core_id,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [9:0]  device_addr,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
`ifdef DEVICE_UART_CORE_TAG_EN
  localparam int FW = 12;
`else
  localparam int FW = 8;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [9:0] off;
  logic sel_st, sel_tx, sel_rx, rd_st, rd_rx, push;
  logic unused_in;
  assign off = device_addr - BASE_ADDR;
  assign sel_st = off == 10'd0;
  assign sel_tx = off == 10'd1;
  assign sel_rx = off == 10'd2;
  assign rd_st = device_read_en && sel_st;
  assign rd_rx = device_read_en && sel_rx;
  assign push = device_write_en && sel_tx;
  assign unused_in = ^{device_core_id, device_data_out[15:8]};
  logic [FW-1:0] mem [TX_FIFO_DEPTH];
  logic [FW-1:0] wdata, head;
  logic [AW:0] wp, rp;
  logic full, empty, pop, load, need_tag;
  logic [7:0] load_byte;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  assign pop = load && !need_tag;
`ifdef DEVICE_UART_CORE_TAG_EN
  logic [3:0] last_tag;
  logic tag_valid;
  assign wdata = {device_core_id, device_data_out[7:0]};
  assign need_tag = !tag_valid || head[11:8] != last_tag;
  assign load_byte = need_tag ? {4'hF, head[11:8]} : head[7:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_tag <= '0;
      tag_valid <= 1'b0;
    end else if (load && need_tag) begin
      last_tag <= head[11:8];
      tag_valid <= 1'b1;
    end
`else
  assign wdata = device_data_out[7:0];
  assign need_tag = 1'b0;
  assign load_byte = head[7:0];
`endif
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  state_t tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic tx_n;
  // A STOP that finds the FIFO non-empty reloads straight into START, so frames abut
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n = tx_cnt == CNT_LAST ? '0 : tx_cnt + 1'b1;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
    load = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        load = !empty;
      end
      START: if (tx_cnt == CNT_LAST) tx_state_n = DATA;
      DATA: if (tx_cnt == CNT_LAST) begin
        tx_bit_n = tx_bit + 1'b1;
        tx_sh_n = tx_sh >> 1;
        tx_state_n = tx_bit == 3'd7 ? STOP : DATA;
      end
      default: if (tx_cnt == CNT_LAST) begin
        load = !empty;
        tx_state_n = IDLE;
      end
    endcase
    if (load) begin
      tx_state_n = START;
      tx_sh_n = load_byte;
    end
    tx_n = tx_state_n == START ? 1'b0 : tx_state_n == DATA ? tx_sh_n[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      uart_tx <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n;
      uart_tx <= tx_n;
    end
  logic rx_s1, rx_s2, rx_prev, deliver, frame_set;
  state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n = rx_cnt == CNT_LAST ? '0 : rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    deliver = 1'b0;
    frame_set = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = START;
      end
      START: if (rx_cnt == CNT_HALF) begin
        rx_cnt_n = '0;
        rx_state_n = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_cnt == CNT_LAST) begin
        rx_sh_n = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 1'b1;
        rx_state_n = rx_bit == 3'd7 ? STOP : DATA;
      end
      default: if (rx_cnt == CNT_LAST) begin
        deliver = rx_s2;
        frame_set = !rx_s2;
        rx_state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh <= rx_sh_n;
    end
  logic rx_valid, rx_overrun, rx_frame_err, tx_overflow;
  logic [7:0] rx_byte;
  logic [15:0] status, rd_mux;
  assign status = {10'h0, tx_overflow, rx_frame_err, rx_overrun, rx_valid, empty, full};
  assign rd_mux = sel_st ? status : sel_rx ? {8'h0, rx_byte} : 16'h0;
  // Sticky bits: a new event in the same cycle as a STATUS read survives the clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      device_data_in <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_overflow <= 1'b0;
      rx_byte <= '0;
    end else begin
      if (device_read_en) device_data_in <= rd_mux;
      tx_overflow <= (push && full) || (tx_overflow && !rd_st);
      rx_frame_err <= frame_set || (rx_frame_err && !rd_st);
      rx_overrun <= (deliver && rx_valid && !rd_rx) || (rx_overrun && !rd_st);
      if (deliver && (!rx_valid || rd_rx)) begin
        rx_byte <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_rx) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_device_uart.sv
// tb_device_uart: directed table and sequence checks of device_uart with CLOCKS_PER_BIT=4, depth 8
module tb_device_uart;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] device_core_id;
  logic device_write_en, device_read_en;
  logic [9:0] device_addr;
  logic [15:0] device_data_out, device_data_in;
  logic uart_tx, uart_rx;
  int tests = 0;
  int fails = 0;

  device_uart #(.BASE_ADDR(10'h000), .CLOCKS_PER_BIT(4), .TX_FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .device_core_id(device_core_id),
    .device_write_en(device_write_en), .device_read_en(device_read_en),
    .device_addr(device_addr), .device_data_out(device_data_out),
    .device_data_in(device_data_in), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] got [10];
  bit got_ok [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [15:0] w);
    device_addr = a;
    device_data_out = w;
    device_write_en = 1'b1;
    @(negedge clk);
    device_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [15:0] r);
    device_addr = a;
    device_read_en = 1'b1;
    @(negedge clk);
    device_read_en = 1'b0;
    r = device_data_in;
  endtask

  // Waits (bounded) for a start bit on uart_tx, then samples each bit mid-way
  task automatic get_frame(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    b = 8'h00;
    while (uart_tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n < 400) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (4) @(negedge clk);
      ok = uart_tx === 1'b1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [39:0] cap, expv;
    logic [9:0] fr;
    int lows;
    reset = 1'b0;
    device_core_id = 4'h0;
    device_write_en = 1'b0;
    device_read_en = 1'b0;
    device_addr = '0;
    device_data_out = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1'b1);
    check("reset_data", device_data_in, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    vecs[0] = '{1'b0, 1'b1, 10'h000, 16'h0000, 16'h0002};
    vecs[1] = '{1'b0, 1'b1, 10'h002, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 10'h003, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 10'h3FF, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 10'h000, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 10'h002, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 10'h005, 16'h00AA, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 10'h002, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 1'b1, 10'h000, 16'h0000, 16'h0002};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      if (vecs[i].re) begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end
    repeat (5) @(negedge clk);
    check("read_hold", device_data_in, 16'h0002);

`ifndef DEVICE_UART_CORE_TAG_EN
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) expv[i] = fr[i / 4];
    bus_write(10'h001, 16'h00A5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cap[i] = uart_tx;
    end
    check("tx_a5_frame", cap, expv);
    @(negedge clk);
    check("tx_a5_idle", uart_tx, 1'b1);
    bus_read(10'h000, d);
    check("tx_a5_status", d, 16'h0002);
`endif

    bus_write(10'h001, 16'h0000);
    repeat (10) @(negedge clk);
    check("midframe_low", uart_tx, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("midframe_reset_tx", uart_tx, 1'b1);
    check("midframe_reset_data", device_data_in, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    bus_read(10'h000, d);
    check("midframe_status", d, 16'h0002);
    lows = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("midframe_abandoned", lows, 0);

`ifndef DEVICE_UART_CORE_TAG_EN
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(10'h001, 16'hAB10 + 16'(i));
        bus_read(10'h000, d);
        check("fifo_overflow_status", d, 16'h0021);
        bus_read(10'h000, d);
        check("fifo_overflow_cleared", d, 16'h0001);
      end
      begin
        for (int i = 0; i < 9; i++) get_frame(got[i], got_ok[i]);
      end
    join
    for (int i = 0; i < 9; i++) begin
      check($sformatf("fifo_byte%0d", i), {got_ok[i], got[i]}, {1'b1, 8'h10 + 8'(i)});
    end
    repeat (2) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("fifo_tenth_dropped", lows, 0);
    bus_read(10'h000, d);
    check("fifo_drained_status", d, 16'h0002);
`else
    fork
      begin
        device_core_id = 4'h3;
        bus_write(10'h001, 16'h0041);
        bus_write(10'h001, 16'h0042);
        device_core_id = 4'h5;
        bus_write(10'h001, 16'h0043);
        device_core_id = 4'h0;
      end
      begin
        for (int i = 0; i < 5; i++) get_frame(got[i], got_ok[i]);
      end
    join
    check("tag_f0", {got_ok[0], got[0]}, {1'b1, 8'hF3});
    check("tag_f1", {got_ok[1], got[1]}, {1'b1, 8'h41});
    check("tag_f2", {got_ok[2], got[2]}, {1'b1, 8'h42});
    check("tag_f3", {got_ok[3], got[3]}, {1'b1, 8'hF5});
    check("tag_f4", {got_ok[4], got[4]}, {1'b1, 8'h43});
`endif

    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(10'h000, d);
    check("rx_valid_status", d, 16'h0006);
    bus_read(10'h002, d);
    check("rx_data_3c", d, 16'h003C);
    bus_read(10'h000, d);
    check("rx_valid_cleared", d, 16'h0002);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(10'h000, d);
    check("rx_overrun_status", d, 16'h000E);
    bus_read(10'h002, d);
    check("rx_overrun_kept_first", d, 16'h0011);
    bus_read(10'h000, d);
    check("rx_overrun_cleared", d, 16'h0002);

    send_rx(8'h77, 1'b1);
    send_rx(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(10'h000, d);
    check("rx_frame_err_status", d, 16'h0016);
    bus_read(10'h002, d);
    check("rx_frame_err_kept", d, 16'h0077);
    bus_read(10'h000, d);
    check("rx_frame_err_cleared", d, 16'h0002);

    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (50) @(negedge clk);
    bus_read(10'h000, d);
    check("rx_glitch_status", d, 16'h0002);
    bus_read(10'h002, d);
    check("rx_stale_read", d, 16'h0077);
    bus_read(10'h000, d);
    check("rx_stale_no_effect", d, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
